// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state type for the registered, handshaked ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MAX  = 4'b0010;
    localparam logic [3:0] OP_MIN  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_XNOR = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between an operand source (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, cout, zero, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, cout, zero, err
    );
endinterface

// File: rtl/alu_comb.sv
// Combinational function of the eight single-cycle ops; any other code yields {cout, y} = 0.
module alu_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    always_comb begin
        y    = '0;
        cout = 1'b0;
        case (op)
            OP_ADD:  {cout, y} = {1'b0, a} + {1'b0, b};
            // The extra top bit of the difference is set exactly when a < b.
            OP_SUB:  {cout, y} = {1'b0, a} - {1'b0, b};
            OP_MAX:  y = (a >= b) ? a : b;
            OP_MIN:  y = (a <= b) ? a : b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, one buffered result and a shift-add multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state, state_next;
    logic [2*WIDTH-1:0] mul_a, acc, acc_next;
    logic [WIDTH-1:0]   mul_b;
    logic [CNT_W-1:0]   count;

    logic               out_valid_q, cout_q, zero_q, err_q;
    logic [WIDTH-1:0]   y_q;

    logic               ready, accept, op_is_mul, op_reserved, mul_done;
    logic [WIDTH-1:0]   comb_y;
    logic               comb_cout;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .a    (bus.a),
        .b    (bus.b),
        .op   (bus.op),
        .y    (comb_y),
        .cout (comb_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && op_is_mul) state_next = ST_MUL;
            ST_MUL:  if (mul_done)            state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        op_is_mul   = (bus.op == OP_MUL);
        op_reserved = bus.op[3] && !op_is_mul;
        ready       = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
        accept      = bus.in_valid && ready;
        mul_done    = (state == ST_MUL) && (count == CNT_W'(WIDTH - 1));
        // mul_b shifts right each iteration, so bit 0 is always the original b[count].
        acc_next    = acc + (mul_b[0] ? mul_a : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_a       <= '0;
            mul_b       <= '0;
            acc         <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (accept && op_is_mul) begin
                mul_a <= {{WIDTH{1'b0}}, bus.a};
                mul_b <= bus.b;
                acc   <= '0;
                count <= '0;
            end else if (state == ST_MUL) begin
                acc   <= acc_next;
                mul_a <= mul_a << 1;
                mul_b <= mul_b >> 1;
                count <= count + CNT_W'(1);
            end

            if (accept && !op_is_mul) begin
                y_q         <= comb_y;
                cout_q      <= comb_cout;
                zero_q      <= (comb_y == '0);
                err_q       <= op_reserved;
                out_valid_q <= 1'b1;
            end else if (mul_done) begin
                y_q         <= acc_next[WIDTH-1:0];
                cout_q      <= |acc_next[2*WIDTH-1:WIDTH];
                zero_q      <= (acc_next[WIDTH-1:0] == '0);
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16: expectations queued on accept, compared on drain.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] y;
        logic         cout;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        exp_t        e;
        logic [31:0] p;
        e = '0;
        case (op)
            4'd0: begin p = 32'(a) + 32'(b); e.y = p[15:0]; e.cout = p[16]; end
            4'd1: begin e.y = a - b; e.cout = (a < b); end
            4'd2: e.y = (a > b) ? a : b;
            4'd3: e.y = (a < b) ? a : b;
            4'd4: e.y = a & b;
            4'd5: e.y = a | b;
            4'd6: e.y = a ^ b;
            4'd7: e.y = ~(a ^ b);
            4'd8: begin p = 32'(a) * 32'(b); e.y = p[15:0]; e.cout = (p[31:16] != 0); end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Drain/accept monitor: inputs are stable at negedge, so this sees exactly what the next edge transfers.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stray_result: got y=%h with nothing expected", bus.y);
                end else begin
                    e = sb.pop_front();
                    if ({bus.y, bus.cout, bus.zero, bus.err} !== {e.y, e.cout, (e.y == 16'h0), e.err}) begin
                        errors++;
                        $display("FAIL scoreboard: got y=%h cout=%b zero=%b err=%b, want y=%h cout=%b zero=%b err=%b",
                                 bus.y, bus.cout, bus.zero, bus.err, e.y, e.cout, (e.y == 16'h0), e.err);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.a, bus.b, bus.op));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] top);
        logic took;
        took = 1'b0;
        bus.a = ta; bus.b = tb; bus.op = top; bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && !took; i++) begin
            @(negedge clk);
            took = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!took) begin
            checks++; errors++;
            $display("FAIL send_timeout: op=%b never accepted", top);
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic stray;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.out_valid, bus.y, bus.cout, bus.zero, bus.err, bus.in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got ov=%b y=%h c=%b z=%b e=%b rdy=%b, want 0 0000 0 0 0 1",
                     bus.out_valid, bus.y, bus.cout, bus.zero, bus.err, bus.in_ready);
        end
        rst_n = 1'b1;
        tick();
        send(16'd5, 16'd7, OP_MUL);
        repeat (3) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        checks++;
        if ({bus.out_valid, bus.y, bus.in_ready} !== {1'b0, 16'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_mul: got ov=%b y=%h rdy=%b, want 0 0000 1", bus.out_valid, bus.y, bus.in_ready);
        end
        stray = 1'b0;
        repeat (W + 4) begin
            tick();
            if (bus.out_valid) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_stray: out_valid rose after aborted mul, want 0");
        end
    endtask

    task automatic test_add_sub_max();
        bus.out_ready = 1'b1;
        send(16'hFFFF, 16'h0001, OP_ADD);
        checks++;
        if ({bus.out_valid, bus.y, bus.cout, bus.zero} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL add_wrap: got ov=%b y=%h c=%b z=%b, want 1 0000 1 1", bus.out_valid, bus.y, bus.cout, bus.zero);
        end
        send(16'd3, 16'd5, OP_SUB);
        checks++;
        if ({bus.y, bus.cout} !== {16'hFFFE, 1'b1}) begin
            errors++;
            $display("FAIL sub_borrow: got y=%h c=%b, want FFFE 1", bus.y, bus.cout);
        end
        send(16'd9, 16'd9, OP_MAX);
        checks++;
        if ({bus.y, bus.cout} !== {16'd9, 1'b0}) begin
            errors++;
            $display("FAIL max_equal: got y=%h c=%b, want 0009 0", bus.y, bus.cout);
        end
        drain();
    endtask

    task automatic mul_check(input logic [W-1:0] ta, input logic [W-1:0] tb,
                             input logic [W-1:0] wy, input logic wc, input logic wz);
        logic early;
        early = 1'b0;
        bus.out_ready = 1'b1;
        send(ta, tb, OP_MUL);
        for (int i = 1; i < W; i++) begin
            if (bus.out_valid || bus.in_ready) early = 1'b1;
            tick();
        end
        if (bus.out_valid || bus.in_ready) early = 1'b1;
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy: out_valid or in_ready high during multiply, want 0");
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.y, bus.cout, bus.zero} !== {1'b1, wy, wc, wz}) begin
            errors++;
            $display("FAIL mul_result: got ov=%b y=%h c=%b z=%b, want 1 %h %b %b",
                     bus.out_valid, bus.y, bus.cout, bus.zero, wy, wc, wz);
        end
        drain();
    endtask

    task automatic test_mul();
        mul_check(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1);
        mul_check(16'd300, 16'd200, 16'd60000, 1'b0, 1'b0);
        mul_check(16'hBEEF, 16'h0000, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic moved;
        moved = 1'b0;
        bus.out_ready = 1'b0;
        send(16'hA5A5, 16'h0F0F, OP_XOR);
        bus.a = 16'hF0F0; bus.b = 16'h3C3C; bus.op = OP_AND; bus.in_valid = 1'b1;
        repeat (5) begin
            if (!bus.out_valid || bus.y !== 16'hAAAA || bus.in_ready) moved = 1'b1;
            tick();
        end
        checks++;
        if (moved !== 1'b0) begin
            errors++;
            $display("FAIL hold: got ov=%b y=%h rdy=%b while stalled, want 1 AAAA 0", bus.out_valid, bus.y, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.y} !== {1'b1, 16'h3030}) begin
            errors++;
            $display("FAIL drain_and_accept: got ov=%b y=%h, want 1 3030", bus.out_valid, bus.y);
        end
        drain();
    endtask

    task automatic test_reserved();
        bus.out_ready = 1'b1;
        send(16'h1234, 16'h5678, 4'b1011);
        checks++;
        if ({bus.out_valid, bus.y, bus.err, bus.cout} !== {1'b1, 16'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reserved: got ov=%b y=%h e=%b c=%b, want 1 0000 1 0", bus.out_valid, bus.y, bus.err, bus.cout);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic gap;
        gap = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.op = 4'(i);
            bus.in_valid = 1'b1;
            if (!bus.in_ready) gap = 1'b1;
            tick();
            if (!bus.out_valid) gap = 1'b1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (gap !== 1'b0) begin
            errors++;
            $display("FAIL stream_rate: a bubble appeared in back-to-back stream, want none");
        end
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stream_drained: %0d results outstanding, want 0", sb.size());
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
        test_reset();
        test_add_sub_max();
        test_mul();
        test_backpressure();
        test_reserved();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
